// File: rtl/mul_seq_pkg.sv
// Shared constants and state encoding for the sequential digit-serial multiplier.
package mul_seq_pkg;

    // Operand digit width and the width of one digit-by-digit partial product.
    localparam int DIG_W = 2;
    localparam int PP_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pp_unit_2x2.sv
// 2x2-bit unsigned multiplier built from AND gates and two half adders.
module pp_unit_2x2
    import mul_seq_pkg::*;
(
    input  logic [DIG_W-1:0] x,
    input  logic [DIG_W-1:0] y,
    output logic [PP_W-1:0]  p
);

    logic t0, t1, t2, t3;
    logic c1;

    // Partial-product bits, then a half adder for column 1 and one for column 2.
    always_comb begin
        t0   = x[0] & y[0];
        t1   = x[1] & y[0];
        t2   = x[0] & y[1];
        t3   = x[1] & y[1];
        c1   = t1 & t2;
        p[0] = t0;
        p[1] = t1 ^ t2;
        p[2] = t3 ^ c1;
        p[3] = t3 & c1;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WxW unsigned multiplier that reuses one 2x2 partial-product unit
// for every digit pair, accumulating into a 2W-bit result.
// Optional macro MUL_SEQ_ZERO_SKIP_EN: a zero operand skips RUN and goes
// straight to DONE with a zero product.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    // W must be even and >= 2; N digits per operand.
    localparam int N  = W / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * W;
    localparam int SW = IW + 2;

    state_t state, state_nxt;

    // Captured operands viewed as arrays of digits so the index selects a digit.
    logic [N-1:0][DIG_W-1:0] a_dig, b_dig;
    logic [IW-1:0]           i, j;
    logic [PW-1:0]           acc;
    logic [PP_W-1:0]         pp;
    logic [PW-1:0]           pp_sh;
    logic [SW-1:0]           sh;
    logic                    accept, out_hs, j_last, last, zero_op;

    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign j_last = (j == IW'(N - 1));
    assign last   = (i == IW'(N - 1)) && j_last;

`ifdef MUL_SEQ_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Single shared partial-product unit, fed by the current digit pair.
    pp_unit_2x2 u_pp (
        .x (a_dig[i]),
        .y (b_dig[j]),
        .p (pp)
    );

    // Weight of digit pair (i,j) is 4^(i+j): shift by 2*(i+j).
    always_comb begin
        sh    = {({1'b0, i} + {1'b0, j}), 1'b0};
        pp_sh = PW'(pp) << sh;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = zero_op ? S_DONE : S_RUN;
            S_RUN:  if (last)   state_nxt = S_DONE;
            S_DONE: if (out_hs) state_nxt = S_IDLE;
            default:            state_nxt = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_RUN);
        out_valid = (state == S_DONE);
    end

    // Operand capture, digit walk and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dig <= '0;
            b_dig <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_dig <= a;
                        b_dig <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                S_RUN: begin
                    acc <= acc + pp_sh;
                    if (last) begin
                        i <= '0;
                        j <= '0;
                    end else if (j_last) begin
                        i <= i + 1'b1;
                        j <= '0;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The accumulator itself is the registered result.
    assign product = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: accepted operands push a*b plus the
// expected latency and RUN length; a monitor checks every presented result.
module tb_mul_seq_ctrl;

    localparam int W = 8;
    localparam int N = W / 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready;
    logic [W-1:0]   a, b;
    logic           out_valid, out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    mul_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        int             acc_cyc;
        int             lat;
        int             bsy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0, hs_cnt = 0, acc_cnt = 0, busy_cnt = 0;
    bit   seen = 0, post_hs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit skips(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_SEQ_ZERO_SKIP_EN
        return (x == 0) || (y == 0);
`else
        return 1'b0;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: every accepted operand pair yields a*b after N*N RUN
    // cycles, or immediately if zero-skip applies.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && in_valid && in_ready) begin
            e.p       = (2*W)'(a) * (2*W)'(b);
            e.acc_cyc = cyc + 1;
            e.lat     = skips(a, b) ? 1 : N * N;
            e.bsy     = skips(a, b) ? 0 : N * N;
            q.push_back(e);
            acc_cnt++;
        end
    end

    // Result monitor.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            seen     = 0;
            post_hs  = 0;
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc - q[0].acc_cyc, q[0].lat);
                        seen = 1;
                    end
                    chk("product", product, q[0].p);
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        chk("busy_cycles", busy_cnt, q[0].bsy);
                        void'(q.pop_front());
                        seen     = 0;
                        busy_cnt = 0;
                        post_hs  = 1;
                        hs_cnt++;
                    end
                end
            end else if (post_hs) begin
                chk("in_ready_after_hs", in_ready, 1);
                post_hs = 0;
            end
        end
    end

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb2, input int rdy_dly);
        int h0;
        bit ok;
        @(posedge clk); #1;
        a = ta; b = tb2; in_valid = 1'b1; out_ready = (rdy_dly == 0);
        h0 = hs_cnt;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk("accept_wait", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        if (rdy_dly > 0) begin
            ok = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (out_valid) begin ok = 1; break; end
            end
            chk("out_valid_wait", ok, 1);
            repeat (rdy_dly) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (hs_cnt != h0) begin ok = 1; break; end
        end
        chk("result_wait", ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a0, h0;
        bit ok;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_txn(8'd3, 8'd5, 0);
        run_txn(8'd255, 8'd255, 0);
        run_txn(8'd200, 8'd123, 10);

        // Abort a multiply mid-RUN with a one-cycle reset.
        @(posedge clk); #1;
        a = 8'd77; b = 8'd91; in_valid = 1'b1; out_ready = 1'b1;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk("abort_accept_wait", ok, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        run_txn(8'd6, 8'd7, 0);

        run_txn(8'd0, 8'd99, 0);
        run_txn(8'd9, 8'd9, 0);
        run_txn(8'd255, 8'd0, 1);

        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_txn(ra, rb, $urandom_range(0, 3));
        end

        // in_valid held high with operands changing every cycle.
        @(posedge clk); #1;
        a0 = acc_cnt; h0 = hs_cnt;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom);
        end
        in_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (q.size() == 0) begin ok = 1; break; end
        end
        chk("hold_drain_wait", ok, 1);
        repeat (2) @(posedge clk);
        chk("hold_results_eq_accepts", hs_cnt - h0, acc_cnt - a0);
        chk("hold_min_accepts", (acc_cnt - a0) >= 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequential controller that time-shares one 2x2-bit partial-product unit to compute an unsigned WxW multiply over multiple cycles.
- Walks every pair of 2-bit operand digits, shifts each 4-bit partial product into place and accumulates it into a 2W-bit result.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

Parameters:
- W, 8, operand width in bits. Must be even and at least 2.
- N, W/2 (derived localparam, not overridable), number of 2-bit digits per operand.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b are valid
- in_ready  output  1  block can accept operands
- a  input  W  multiplicand, unsigned
- b  input  W  multiplier, unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts product
- product  output  2W  unsigned a*b
- busy  output  1  high while in RUN

Behaviour:
- Reset: one clock, synchronous active-high reset (clk, rst).
  - rst sampled high at a rising edge: state=IDLE, acc=0, digit indices i=j=0, operand registers=0.
  - Output values during/after reset: in_ready=1, out_valid=0, busy=0, product=0.
  - rst mid-operation aborts the multiply; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: capture a and b, acc<=0, i<=0, j<=0, go to RUN.
- RUN:
  - in_ready=0, busy=1. in_valid is ignored and operands are not re-sampled.
  - Each cycle: pp = a[2i+1:2i] * b[2j+1:2j] (4 bits, max 9), taken from the partial-product unit.
  - acc <= acc + (pp << 2*(i+j)). Additions are 2W bits wide and never overflow, since the final value is at most (2^W-1)^2.
  - Index walk: j increments each cycle. When j==N-1, j wraps to 0 and i increments.
  - After the cycle with i==N-1 and j==N-1 (the last accumulate), go to DONE.
- Latency:
  - RUN lasts exactly N*N cycles.
  - out_valid is first visible after edge E0+N*N: 16 cycles for W=8, 1 cycle for W=2.
- DONE:
  - out_valid=1, product=acc. product is held stable while out_ready=0, for any number of cycles.
  - On out_valid&&out_ready: go to IDLE, out_valid<=0.
  - in_ready stays 0 during DONE, even in the handshake cycle, so there is no same-cycle turnaround. The next operands are accepted at the earliest one cycle after the result handshake.
- product is registered (driven from acc). It is held at its last value outside DONE and is only meaningful while out_valid=1.
- Boundary conditions:
  - in_valid may be held high continuously. One transaction is taken per IDLE visit.
  - a or b equal to 0 still runs the full N*N cycles, unless the optional feature below is enabled.
  - Full-scale operands (a=b=2^W-1) must produce the exact 2W-bit result with no truncation.

Optional Feature:
- Macro: MUL_SEQ_ZERO_SKIP_EN.
- Defined:
  - At the accepting edge, if a==0 or b==0: acc<=0 and the FSM goes straight to DONE. out_valid is visible after E0+1, and busy never asserts.
  - Non-zero operands behave exactly as without the macro.
- Undefined: no zero detection; every transaction takes N*N RUN cycles.

Decomposition:
- Shared package/include mul_seq_pkg:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - digit-width constant DIG_W=2;
  - partial-product width constant PP_W=4.
- One sub-module, pp_unit_2x2: purely combinational 2x2 unsigned multiplier (2-bit x, 2-bit y -> 4-bit p) built from AND gates and half adders.
- The controller instantiates exactly one pp_unit_2x2 and selects its inputs with the digit indices.
- The FSM, index counters and accumulator stay in mul_seq_ctrl.

Test Plan:
- W=8, a=3, b=5, out_ready=1 -> out_valid rises 16 cycles after accept, product=15, then in_ready=1 one cycle after the result handshake.
- W=8, a=255, b=255 -> product=65025 (16'hFE01); busy high for exactly 16 cycles.
- W=8, a=200, b=123, out_ready=0 for 10 cycles after out_valid -> product=24600 held stable, in_ready=0 throughout, single handshake when out_ready rises.
- W=8, a=77, b=91, rst=1 for one cycle at RUN cycle 7 -> next cycle state IDLE, out_valid=0, product=0, in_ready=1; a new transaction a=6, b=7 then yields 42.
- W=8, in_valid held high with a changing every cycle during RUN -> the captured first operands determine the result; exactly one result is produced per IDLE visit.
- W=8 with MUL_SEQ_ZERO_SKIP_EN defined:
  - a=0, b=99 -> out_valid after 1 cycle, product=0, busy never high.
  - a=9, b=9 -> 16-cycle latency, product=81.
